// File: rtl/sound_frame_seq.sv
// APU frame sequencer: divides the system clock to 512 Hz, walks an 8-step
// sequence and emits fixed-width length / sweep / envelope strobes.
module sound_frame_seq #(
    parameter int unsigned DIV_RATIO    = 8192,
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_en,
    input  logic       div_reset,
    output logic [2:0] step,
    output logic       tick_512,
    output logic       clk_length,
    output logic       clk_sweep,
    output logic       clk_vol_env
);

    localparam int unsigned PW = $clog2(DIV_RATIO);
    localparam int unsigned CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_RATIO - 1);
    localparam logic [CW-1:0] PCNT_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [2:0]    STEP_RST  = 3'd7;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;
    logic          len_q, len_d;
    logic          sweep_q, sweep_d;
    logic          env_q, env_d;
    logic [2:0]    step_nx;

    assign step_nx = step_q + 3'd1;

    // Next-state: disable dominates, then prescaler restart, then terminal count
    always_comb begin
        presc_d = presc_q + PW'(1);
        step_d  = step_q;
        pcnt_d  = pcnt_q;
        tick_d  = 1'b0;
        len_d   = len_q;
        sweep_d = sweep_q;
        env_d   = env_q;

        // Pulse-width countdown runs whenever no new step is entered
        if (pcnt_q == '0) begin
            len_d   = 1'b0;
            sweep_d = 1'b0;
            env_d   = 1'b0;
        end else begin
            pcnt_d = pcnt_q - CW'(1);
        end

        if (!apu_en) begin
            presc_d = '0;
            step_d  = STEP_RST;
            pcnt_d  = '0;
            len_d   = 1'b0;
            sweep_d = 1'b0;
            env_d   = 1'b0;
        end else if (div_reset) begin
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            step_d  = step_nx;
            tick_d  = 1'b1;
            pcnt_d  = PCNT_LOAD;
            len_d   = ~step_nx[0];
            sweep_d = (step_nx == 3'd2) || (step_nx == 3'd6);
            env_d   = (step_nx == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            step_q  <= STEP_RST;
            pcnt_q  <= '0;
            tick_q  <= 1'b0;
            len_q   <= 1'b0;
            sweep_q <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            pcnt_q  <= pcnt_d;
            tick_q  <= tick_d;
            len_q   <= len_d;
            sweep_q <= sweep_d;
            env_q   <= env_d;
        end
    end

    assign step        = step_q;
    assign tick_512    = tick_q;
    assign clk_length  = len_q;
    assign clk_sweep   = sweep_q;
    assign clk_vol_env = env_q;

endmodule

// File: tb/tb_sound_frame_seq.sv
// Bench for sound_frame_seq: two instances (pulse width 2 and 7) checked every
// cycle against a behavioural model, plus a vector table and corner sequences.
module tb_sound_frame_seq;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic apu_en = 1'b1;
    logic div_reset = 1'b0;

    logic [2:0] step_a, step_b;
    logic tick_a, len_a, sw_a, env_a;
    logic tick_b, len_b, sw_b, env_b;

    int n_checks = 0;
    int n_errors = 0;

    sound_frame_seq #(.DIV_RATIO(N), .PULSE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .apu_en(apu_en), .div_reset(div_reset),
        .step(step_a), .tick_512(tick_a), .clk_length(len_a),
        .clk_sweep(sw_a), .clk_vol_env(env_a)
    );

    sound_frame_seq #(.DIV_RATIO(N), .PULSE_CYCLES(7)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .apu_en(apu_en), .div_reset(div_reset),
        .step(step_b), .tick_512(tick_b), .clk_length(len_b),
        .clk_sweep(sw_b), .clk_vol_env(env_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: strobes as "cycles of high time remaining"
    int m_presc;
    int m_step;
    int m_tick;
    int m_rem [2][3];
    int widths [2] = '{2, 7};

    function automatic bit fires(input int s, input int k);
        case (k)
            0:       return (s % 2) == 0;
            1:       return (s == 2) || (s == 6);
            default: return s == 7;
        endcase
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_step  = 7;
        m_tick  = 0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) m_rem[i][k] = 0;
    endtask

    task automatic model_drain();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                if (m_rem[i][k] > 0) m_rem[i][k]--;
    endtask

    task automatic model_edge();
        if (!rst_n || !apu_en) begin
            model_reset();
        end else if (div_reset) begin
            m_presc = 0;
            m_tick  = 0;
            model_drain();
        end else if (m_presc == int'(N) - 1) begin
            m_presc = 0;
            m_step  = (m_step + 1) % 8;
            m_tick  = 1;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 3; k++)
                    m_rem[i][k] = fires(m_step, k) ? widths[i] : 0;
        end else begin
            m_presc++;
            m_tick = 0;
            model_drain();
        end
    endtask

    initial model_reset();

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        model_edge();
        #1;
        chk("m_step_a", step_a, m_step);
        chk("m_tick_a", tick_a, m_tick);
        chk("m_len_a",  len_a,  int'(m_rem[0][0] > 0));
        chk("m_sw_a",   sw_a,   int'(m_rem[0][1] > 0));
        chk("m_env_a",  env_a,  int'(m_rem[0][2] > 0));
        chk("m_step_b", step_b, m_step);
        chk("m_tick_b", tick_b, m_tick);
        chk("m_len_b",  len_b,  int'(m_rem[1][0] > 0));
        chk("m_sw_b",   sw_b,   int'(m_rem[1][1] > 0));
        chk("m_env_b",  env_b,  int'(m_rem[1][2] > 0));
    end

    typedef struct {
        logic        en;
        logic        dr;
        int unsigned cyc;
        logic [2:0]  step;
        logic        tick;
        logic        len;
        logic        sw;
        logic        env;
    } vec_t;

    vec_t vecs [13];

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_outs_a(input string nm, input int s, input int t,
                              input int l, input int w, input int e);
        chk({nm, "_step"}, step_a, s);
        chk({nm, "_tick"}, tick_a, t);
        chk({nm, "_len"},  len_a,  l);
        chk({nm, "_sw"},   sw_a,   w);
        chk({nm, "_env"},  env_a,  e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at %0t: got no finish expected finish", $time);
        $fatal(1);
    end

    initial begin
        // Reset sequence: {en, dr, cycles, step, tick, len, sweep, env}
        vecs[0]  = '{1'b1, 1'b0, 1,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 6,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1,  3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 6,  3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8,  3'd2, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1,  3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 39, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1,  3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 7,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            apu_en    = vecs[i].en;
            div_reset = vecs[i].dr;
            run(int'(vecs[i].cyc));
            chk_outs_a($sformatf("vec%0d", i), vecs[i].step, vecs[i].tick,
                       vecs[i].len, vecs[i].sw, vecs[i].env);
        end

        // Prescaler restart mid-count, then exactly on the terminal count
        apu_en = 1'b1;
        do_reset();
        run(4);
        div_reset = 1'b1;
        run(1);
        div_reset = 1'b0;
        chk("dr_presc", int'(u_dut_a.presc_q), 0);
        run(7);
        chk_outs_a("dr_e12", 7, 0, 0, 0, 0);
        run(1);
        chk_outs_a("dr_e13", 0, 1, 1, 0, 0);
        run(7);
        div_reset = 1'b1;
        run(1);
        div_reset = 1'b0;
        chk_outs_a("dr_tc", 0, 0, 0, 0, 0);
        run(7);
        chk("dr_e28_tick", tick_a, 0);
        run(1);
        chk_outs_a("dr_e29", 1, 1, 0, 0, 0);

        // Enable drop while a length strobe is high
        do_reset();
        for (int c = 0; c < 20 && len_a !== 1'b1; c++) run(1);
        chk("en_wait_len", len_a, 1);
        apu_en = 1'b0;
        run(1);
        chk_outs_a("en_drop", 7, 0, 0, 0, 0);
        chk("en_drop_presc", int'(u_dut_a.presc_q), 0);
        apu_en = 1'b1;
        run(7);
        chk_outs_a("en_pre", 7, 0, 0, 0, 0);
        run(1);
        chk_outs_a("en_first", 0, 1, 1, 0, 0);

        // Asynchronous reset between edges while the envelope strobe is high
        for (int c = 0; c < 100 && env_a !== 1'b1; c++) run(1);
        chk("ar_wait_env", env_a, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs_a("ar_now", 7, 0, 0, 0, 0);
        chk("ar_now_env_b", env_b, 0);
        rst_n = 1'b1;
        run(7);
        chk_outs_a("ar_e7", 7, 0, 0, 0, 0);
        run(1);
        chk_outs_a("ar_e8", 0, 1, 1, 0, 0);

        // Randomised enable / prescaler-restart traffic against the model
        for (int i = 0; i < 600; i++) begin
            apu_en    = ($urandom_range(0, 59) != 0);
            div_reset = ($urandom_range(0, 24) == 0);
            run(1);
        end
        apu_en    = 1'b1;
        div_reset = 1'b0;
        run(80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
